// File: rtl/rv32_inst_encoder.sv
// Packs RV32I instruction fields into a 32-bit word, range-checks the immediate and emits it with a running imem byte address.
// IDLE accepts a bundle, ENC builds and checks the word, EMIT holds it until the downstream handshake.
module rv32_inst_encoder #(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [15:0]       count
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_EMIT} state_t;

  state_t              state_q, state_d;
  logic [2:0]          fmt_q;
  logic [6:0]          op_q, f7_q;
  logic [2:0]          f3_q;
  logic [4:0]          rd_q, rs1_q, rs2_q;
  logic [31:0]         imm_q;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         count_q, count_d;
  logic                err_pulse_q, err_pulse_d;
  logic                err_sticky_q, err_sticky_d;

  logic                capture;
  logic                is_shift;
  logic signed [31:0]  simm;
  logic [31:0]         enc_word;
  logic                enc_ok;

  assign capture  = (state_q == S_IDLE) && in_valid;
  assign simm     = imm_q;
  // OP-IMM shifts carry funct7 in the upper immediate bits and a 5-bit shamt
  assign is_shift = (op_q == 7'h13) && ((f3_q == 3'b001) || (f3_q == 3'b101));

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (fmt_q)
      3'd0: begin
        enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
        enc_ok   = 1'b1;
      end
      3'd1: begin
        if (is_shift) begin
          enc_word = {f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, op_q};
          enc_ok   = (imm_q < 32'd32);
        end else begin
          enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
          enc_ok   = (simm >= -32'sd2048) && (simm <= 32'sd2047);
        end
      end
      3'd2: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
        enc_ok   = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      end
      3'd3: begin
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
        enc_ok   = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm_q[0];
      end
      3'd4: begin
        enc_word = {imm_q[31:12], rd_q, op_q};
        enc_ok   = (imm_q[11:0] == 12'd0);
      end
      3'd5: begin
        enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
        enc_ok   = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm_q[0];
      end
      default: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    addr_d       = addr_q;
    count_d      = count_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    if (restart && (state_q != S_EMIT)) begin
      addr_d       = BASE_ADDR;
      count_d      = '0;
      err_sticky_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_ENC;
      end
      S_ENC: begin
        if (enc_ok) begin
          state_d = S_EMIT;
          word_d  = enc_word;
        end else begin
          state_d      = S_IDLE;
          err_pulse_d  = 1'b1;
          err_sticky_d = 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          addr_d  = addr_q + ADDR_W'(4);
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      addr_q       <= BASE_ADDR;
      count_q      <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fmt_q <= '0;
      op_q  <= '0;
      f3_q  <= '0;
      f7_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (capture) begin
      fmt_q <= fmt;
      op_q  <= opcode;
      f3_q  <= funct3;
      f7_q  <= funct7;
      rd_q  <= rd;
      rs1_q <= rs1;
      rs2_q <= rs2;
      imm_q <= imm;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_EMIT);
  assign out_word   = word_q;
  assign out_addr   = addr_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign count      = count_q;

endmodule
